tx_unit: RTL

TX_UNIT -- requirements
Module: tx_unit

---
 rtl/tx_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tx_unit.sv
// tx_unit: UART-style serial transmitter.
//
// Frame: start bit (0), data_in[0]..data_in[7] LSB first, optional parity bit, stop bit (1).
// Each bit lasts DIV = round(CLK_FREQ / baud) clock cycles.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   send         in   transmit request, honoured only while idle
//   data_in[7:0] in   byte to transmit
//   parity_type  in   00 none, 01 odd, 10 even, 11 none
//   baud_rate    in   00 2400, 01 4800, 10 9600, 11 19200
//   data_tx      out  serial line, idle high (registered)
//   active_flag  out  high while a frame is on the line (registered)
//   done_flag    out  one-cycle pulse in the first idle cycle after a frame (registered)
module tx_unit #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  // Rounded bit periods for each baud selection.
  localparam int unsigned Div2400  = (CLK_FREQ + 1200) / 2400;
  localparam int unsigned Div4800  = (CLK_FREQ + 2400) / 4800;
  localparam int unsigned Div9600  = (CLK_FREQ + 4800) / 9600;
  localparam int unsigned Div19200 = (CLK_FREQ + 9600) / 19200;

  // Counter holds 0..DIV-1 of the slowest rate; never narrower than 15 bits.
  localparam int unsigned CntW = ($clog2(Div2400) > 15) ? $clog2(Div2400) : 15;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_data;
  logic [1:0]      r_parity_type;
  logic [1:0]      r_baud;
  logic            r_tx;
  logic            r_active;
  logic            r_done;

  logic [CntW-1:0] w_div;
  logic            w_bit_end;
  logic            w_parity_en;
  logic            w_parity_bit;
  logic [2:0]      w_next_idx;

  always_comb begin
    w_div = CntW'(Div2400);
    case (r_baud)
      2'b00:   w_div = CntW'(Div2400);
      2'b01:   w_div = CntW'(Div4800);
      2'b10:   w_div = CntW'(Div9600);
      default: w_div = CntW'(Div19200);
    endcase
  end

  assign w_bit_end    = (r_cnt == (w_div - CntW'(1)));
  assign w_parity_en  = (r_parity_type == 2'b01) || (r_parity_type == 2'b10);
  // Odd: make total ones odd; even: make total ones even.
  assign w_parity_bit = (r_parity_type == 2'b01) ? ~(^r_data) : (^r_data);
  assign w_next_idx   = r_idx + 3'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_data        <= '0;
      r_parity_type <= '0;
      r_baud        <= '0;
      r_tx          <= 1'b1;
      r_active      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          // The done cycle is an idle cycle, so back-to-back frames need no gap.
          if (send) begin
            r_data        <= data_in;
            r_parity_type <= parity_type;
            r_baud        <= baud_rate;
            r_state       <= StStart;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_tx          <= 1'b0;
            r_active      <= 1'b1;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_state <= StData;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_data[0];
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_idx <= '0;
              if (w_parity_en) begin
                r_state <= StParity;
                r_tx    <= w_parity_bit;
              end else begin
                r_state <= StStop;
                r_tx    <= 1'b1;
              end
            end else begin
              r_idx <= w_next_idx;
              r_tx  <= r_data[w_next_idx];
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_state <= StStop;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state  <= StIdle;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_tx     <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign data_tx     = r_tx;
  assign active_flag = r_active;
  assign done_flag   = r_done;

endmodule
